fifo_rd_stream: RTL

Read-side adapter that sits directly downstream of the synchronous FIFO. It drains the FIFO through its `rd_en`/`empty`/`d_out` port and presents the words on a valid/ready stream. The FIFO returns read data one cycle after `rd_en`, so the adapter tracks in-flight reads and holds them in a 2-entry output buffer. This gives full-throughput streaming under backpressure with no lost or duplicated words.

---
 rtl/fifo_rd_stream_if.sv | 23 ++
 rtl/fifo_rd_stream.sv | 71 +++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// Handshake bundle between the FIFO read port, the read adapter and the downstream stream sink.
// The adapter uses the master modport; the FIFO/sink side uses slave.
interface fifo_rd_stream_if #(
    parameter int unsigned Width = 8
);
    logic             fifo_rd_en;
    logic             fifo_empty;
    logic [Width-1:0] fifo_d_out;
    logic             m_valid;
    logic             m_ready;
    logic [Width-1:0] m_data;
    logic [15:0]      beat_count;

    modport master (
        output fifo_rd_en, m_valid, m_data, beat_count,
        input  fifo_empty, fifo_d_out, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_valid, m_data, beat_count,
        output fifo_empty, fifo_d_out, m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: turns the FIFO's one-cycle-latency rd_en/d_out port into a
// valid/ready stream with a 2-entry buffer, sized so backpressure never loses a word.
module fifo_rd_stream #(
    parameter int unsigned Width = 8
) (
    input logic             clk,
    input logic             rst,
    fifo_rd_stream_if.master bus
);
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [15:0]      beat_q, beat_d;
    logic [Width-1:0] buf0_q, buf0_d;
    logic [Width-1:0] buf1_q, buf1_d;
    logic             pop;
    logic [2:0]       credit;
    logic             rd_en;

    assign pop = (occ_q != 2'd0) && bus.m_ready;

    // occ + inflight never exceeds 2, so the credit cannot underflow.
    assign credit = 3'd2 + {2'b0, pop} - {1'b0, occ_q} - {2'b0, inflight_q};
    assign rd_en  = rst && !bus.fifo_empty && (credit != 3'd0);

    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        inflight_d = rd_en;
        beat_d     = pop ? beat_q + 16'd1 : beat_q;
        if (pop) begin
            buf0_d = buf1_q;
            if (inflight_q) begin
                if (occ_q == 2'd1) begin
                    buf0_d = bus.fifo_d_out;
                end else begin
                    buf1_d = bus.fifo_d_out;
                end
            end
        end else if (inflight_q) begin
            if (occ_q == 2'd0) begin
                buf0_d = bus.fifo_d_out;
            end else begin
                buf1_d = bus.fifo_d_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
        end
    end

    // Data slots carry no reset; they are only observed while occupancy marks them valid.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = buf0_q;
    assign bus.beat_count = beat_q;
endmodule
